// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder: opcodes, address width, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_mem_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef logic [ADDR_W-1:0] addr_t;

    // One-hot state encoding
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_CMD    = 6'b000010,
        S_ADDR   = 6'b000100,
        S_RD     = 6'b001000,
        S_WR     = 6'b010000,
        S_IGNORE = 6'b100000
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for sclk/cs_n/mosi plus edge detection on the synchronized sclk and cs_n.
// Latency: 2 clk to synchronized level; edge strobes are valid in the cycle the new level appears.
// Backpressure: none; every edge produces a single-cycle strobe.
module spi_sync_edge
    import spi_mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_s,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [1:0] sclk_ff;
    logic [1:0] cs_ff;
    logic [1:0] mosi_ff;
    logic       sclk_d;
    logic       cs_d;

    // Synchronizer chains plus one extra delay stage for edge detection; presets avoid fake edges out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_ff <= 2'b00;
            cs_ff   <= 2'b11;
            mosi_ff <= 2'b00;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            cs_ff   <= {cs_ff[0], cs_n};
            mosi_ff <= {mosi_ff[0], mosi};
            sclk_d  <= sclk_ff[1];
            cs_d    <= cs_ff[1];
        end
    end

    assign sclk_s    = sclk_ff[1];
    assign cs_n_s    = cs_ff[1];
    assign mosi_s    = mosi_ff[1];
    assign sclk_rise =  sclk_ff[1] & ~sclk_d;
    assign sclk_fall = ~sclk_ff[1] &  sclk_d;
    assign cs_fall   = ~cs_ff[1]   &  cs_d;
    assign cs_rise   =  cs_ff[1]   & ~cs_d;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target bridging READ (0x03) / WRITE (0x02) commands with 24-bit address onto a byte memory port.
// Latency: strobes issue 3 clk after the byte-completing sclk edge at the pin; miso updates 3 clk after sclk fall.
// Backpressure: none; the initiator paces everything and the memory must answer reads exactly 1 clk after mem_re.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int SCLK_MIN_RATIO = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic [23:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        busy
);

    logic   sclk_s;
    logic   cs_n_s;
    logic   mosi_s;
    logic   sclk_rise;
    logic   sclk_fall;
    logic   cs_fall;
    logic   cs_rise;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  tx;
    logic [7:0]  hold;
    logic        re_d;
    logic        is_rd;
    addr_t       addr;
    logic        re_set;
    logic        we_set;
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic [7:0]  sclk_high_cnt;

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_s    (sclk_s),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift[6:0], mosi_s};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and strobe requests; RD/WR strobes still fire when cs_n rises on the completing edge
    always_comb begin
        state_nx = state;
        re_set   = 1'b0;
        we_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_fall) state_nx = S_CMD;
            end
            S_CMD: begin
                if (cs_rise) begin
                    state_nx = S_IDLE;
                end else if (byte_done) begin
                    state_nx = (rx_byte == OP_READ || rx_byte == OP_WRITE) ? S_ADDR : S_IGNORE;
                end
            end
            S_ADDR: begin
                if (cs_rise) begin
                    state_nx = S_IDLE;
                end else if (byte_done && byte_cnt == 2'd2) begin
                    state_nx = is_rd ? S_RD : S_WR;
                    re_set   = is_rd;
                end
            end
            S_RD: begin
                re_set = byte_done;
                if (cs_rise) state_nx = S_IDLE;
            end
            S_WR: begin
                we_set = byte_done;
                if (cs_rise) state_nx = S_IDLE;
            end
            S_IGNORE: begin
                if (cs_rise) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: counters, shifters, address pointer, memory strobes and read hold byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shift     <= 24'd0;
            tx        <= 8'd0;
            hold      <= 8'd0;
            re_d      <= 1'b0;
            is_rd     <= 1'b0;
            addr      <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
        end else begin
            mem_re <= re_set;
            mem_we <= we_set;
            re_d   <= mem_re;
            if (re_d) hold <= mem_rdata;
            if (we_set) mem_wdata <= rx_byte;
            // Post-increment after each strobe; natural 24-bit wrap
            if (mem_re || mem_we) addr <= addr + 24'd1;

            if (state == S_IDLE || cs_rise) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 2'd0;
                shift    <= 24'd0;
                tx       <= 8'd0;
            end else begin
                if (sclk_rise) begin
                    shift   <= {shift[22:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
                    if (state == S_CMD && bit_cnt == 3'd7) begin
                        is_rd    <= (rx_byte == OP_READ);
                        byte_cnt <= 2'd0;
                    end
                    if (state == S_ADDR && bit_cnt == 3'd7 && byte_cnt == 2'd2) begin
                        addr <= {shift[22:0], mosi_s};
                    end
                end
                // First falling edge of each byte loads the prefetched byte, the rest shift it out
                if (sclk_fall && state == S_RD) begin
                    tx <= (bit_cnt == 3'd0) ? hold : {tx[6:0], 1'b0};
                end
            end
        end
    end

    // Track how long synchronized sclk has been high, to check the initiator respects the clock ratio
    always_ff @(posedge clk) begin
        if (!rst_n || !sclk_s) begin
            sclk_high_cnt <= 8'd0;
        end else if (sclk_high_cnt != 8'hFF) begin
            sclk_high_cnt <= sclk_high_cnt + 8'd1;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        sclk_fall |-> (sclk_high_cnt >= 8'(SCLK_MIN_RATIO / 2 - 1)));

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_re && mem_we));

    assign miso     = (state == S_RD) ? tx[7] : 1'b0;
    assign mem_addr = addr;
    assign busy     = ~cs_n_s;

endmodule

// File: tb/tb_spi_mem_responder.sv
module tb_spi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [23:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_both = 0;
    int lat;

    logic [7:0]  store [logic [23:0]];
    logic [23:0] log_a [$];
    logic [7:0]  log_d [$];
    logic        log_w [$];

    typedef struct packed {
        logic [63:0] name;
        logic [7:0]  op;
        logic [23:0] addr;
        logic [2:0]  nbytes;
        logic [31:0] dat;
        logic [3:0]  n_re;
        logic [3:0]  n_we;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [15:0] wd;
        logic [31:0] rx;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] rxw;
    logic [7:0]  r8;
    logic        r1;

    spi_mem_responder #(.SCLK_MIN_RATIO(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Backing store: read data appears one clk after mem_re
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= store.exists(mem_addr) ? store[mem_addr] : 8'h00;
        if (mem_we) store[mem_addr] = mem_wdata;
    end

    // Strobe log
    always @(negedge clk) begin
        if (mem_re && mem_we) n_both++;
        if (mem_re) begin
            log_a.push_back(mem_addr); log_d.push_back(8'h00); log_w.push_back(1'b0);
        end
        if (mem_we) begin
            log_a.push_back(mem_addr); log_d.push_back(mem_wdata); log_w.push_back(1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int count_kind(input logic w);
        int c = 0;
        foreach (log_w[i]) if (log_w[i] == w) c++;
        return c;
    endfunction

    function automatic logic [23:0] get_a(input int k);
        return (log_a.size() > k) ? log_a[k] : 24'hxxxxxx;
    endfunction

    function automatic logic [7:0] get_d(input int k);
        return (log_d.size() > k) ? log_d[k] : 8'hxx;
    endfunction

    task automatic clear_log();
        log_a.delete(); log_d.delete(); log_w.delete();
    endtask

    // One sclk period: mosi set while sclk low, miso sampled just before the rising edge
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (4) @(negedge clk);
        r = miso;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic t;
        for (int k = 7; k >= 0; k--) begin
            spi_bit(b[k], t);
            r[k] = t;
        end
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input int nb,
                           input logic [31:0] d, output logic [31:0] rx);
        logic [7:0] r;
        rx = 32'h0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(op, r);
        spi_byte(a[23:16], r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        for (int i = 0; i < nb; i++) begin
            spi_byte(d[31-8*i -: 8], r);
            rx[31-8*i -: 8] = r;
        end
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        store[24'h000010] = 8'h11; store[24'h000011] = 8'h22;
        store[24'h000012] = 8'h33; store[24'h000013] = 8'h44;
        store[24'h000014] = 8'h55; store[24'hFFFFFF] = 8'h5A;
        store[24'h000000] = 8'hA5; store[24'h000001] = 8'h3C;

        //         name        op     addr        nb    data          re    we    a0           a1           wd        miso
        vecs[0] = '{"rd_00010", 8'h03, 24'h000010, 3'd4, 32'h00000000, 4'd5, 4'd0, 24'h000010, 24'h000011, 16'h0000, 32'h11223344};
        vecs[1] = '{"wr_00100", 8'h02, 24'h000100, 3'd2, 32'hAABB0000, 4'd0, 4'd2, 24'h000100, 24'h000101, 16'hAABB, 32'h00000000};
        vecs[2] = '{"rd_wrap_", 8'h03, 24'hFFFFFF, 3'd2, 32'h00000000, 4'd3, 4'd0, 24'hFFFFFF, 24'h000000, 16'h0000, 32'h5AA50000};
        vecs[3] = '{"bad_op0b", 8'h0B, 24'hA5A5A5, 3'd2, 32'hFFFF0000, 4'd0, 4'd0, 24'h000000, 24'h000000, 16'h0000, 32'h00000000};
        vecs[4] = '{"rd_00012", 8'h03, 24'h000012, 3'd2, 32'h00000000, 4'd3, 4'd0, 24'h000012, 24'h000013, 16'h0000, 32'h33440000};
        vecs[5] = '{"wr_00200", 8'h02, 24'h000200, 3'd3, 32'hDEADBE00, 4'd0, 4'd3, 24'h000200, 24'h000201, 16'hDEAD, 32'h00000000};
        vecs[6] = '{"rb_00200", 8'h03, 24'h000200, 3'd3, 32'h00000000, 4'd4, 4'd0, 24'h000200, 24'h000201, 16'h0000, 32'hDEADBE00};
        vecs[7] = '{"rb_00100", 8'h03, 24'h000100, 3'd2, 32'h00000000, 4'd3, 4'd0, 24'h000100, 24'h000101, 16'h0000, 32'hAABB0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_miso",  64'(miso), 64'd0);
        chk("rst_re",    64'(mem_re), 64'd0);
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            clear_log();
            run_txn(vecs[i].op, vecs[i].addr, int'(vecs[i].nbytes), vecs[i].dat, rxw);
            chk($sformatf("%s_nre", vecs[i].name), 64'(count_kind(1'b0)), 64'(vecs[i].n_re));
            chk($sformatf("%s_nwe", vecs[i].name), 64'(count_kind(1'b1)), 64'(vecs[i].n_we));
            if (vecs[i].n_re + vecs[i].n_we >= 5'd1)
                chk($sformatf("%s_a0", vecs[i].name), 64'(get_a(0)), 64'(vecs[i].a0));
            if (vecs[i].n_re + vecs[i].n_we >= 5'd2)
                chk($sformatf("%s_a1", vecs[i].name), 64'(get_a(1)), 64'(vecs[i].a1));
            if (vecs[i].n_we >= 4'd2)
                chk($sformatf("%s_wd", vecs[i].name), 64'({get_d(0), get_d(1)}), 64'(vecs[i].wd));
            chk($sformatf("%s_miso", vecs[i].name), 64'(rxw), 64'(vecs[i].rx));
            chk($sformatf("%s_busy", vecs[i].name), 64'(busy), 64'd0);
        end

        // Abort: one full write byte then 5 bits of the next, cs_n raised
        clear_log();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h02, r8); spi_byte(8'h00, r8); spi_byte(8'h00, r8); spi_byte(8'h20, r8);
        spi_byte(8'hCD, r8);
        for (int k = 0; k < 5; k++) spi_bit(1'b1, r1);
        repeat (2) @(negedge clk);
        lat = 99;
        cs_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (!busy && lat == 99) lat = c;
        end
        n_cmp++;
        if (lat > 3) begin
            n_bad++;
            $display("FAIL abort_busy: busy fell after %0d clk, required <= 3", lat);
        end
        repeat (6) @(negedge clk);
        chk("abort_nwe", 64'(count_kind(1'b1)), 64'd1);
        chk("abort_nre", 64'(count_kind(1'b0)), 64'd0);
        chk("abort_a0",  64'(get_a(0)), 64'h20);
        chk("abort_d0",  64'(get_d(0)), 64'hCD);

        // cs_n rises together with the byte-completing sclk edge: the write still lands
        clear_log();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h02, r8); spi_byte(8'h00, r8); spi_byte(8'h03, r8); spi_byte(8'h00, r8);
        for (int k = 7; k >= 1; k--) spi_bit(r8[0] | (8'h96 >> k) & 8'h01 ? 1'b1 : 1'b0, r1);
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        chk("coinc_nwe", 64'(count_kind(1'b1)), 64'd1);
        chk("coinc_a0",  64'(get_a(0)), 64'h300);
        chk("coinc_d0",  64'(get_d(0)), 64'h96);

        // Reset during address phase
        clear_log();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h03, r8); spi_byte(8'h00, r8);
        for (int k = 0; k < 4; k++) spi_bit(1'b0, r1);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        @(negedge clk);
        chk("mrst_miso",  64'(miso), 64'd0);
        chk("mrst_re",    64'(mem_re), 64'd0);
        chk("mrst_we",    64'(mem_we), 64'd0);
        chk("mrst_addr",  64'(mem_addr), 64'd0);
        chk("mrst_wdata", 64'(mem_wdata), 64'd0);
        chk("mrst_busy",  64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_nstb", 64'(log_w.size()), 64'd0);
        run_txn(8'h03, 24'h000010, 2, 32'h0, rxw);
        chk("mrst_rd_nre",  64'(count_kind(1'b0)), 64'd3);
        chk("mrst_rd_a0",   64'(get_a(0)), 64'h10);
        chk("mrst_rd_miso", 64'(rxw), 64'h11220000);

        chk("no_overlap", 64'(n_both), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
